// File: rtl/pipeline_stall_controller_pkg.sv
// Shared types and control encodings for the pipeline stall controller and the datapath
// that consumes its per-stage enables and flushes.
package pipeline_stall_controller_pkg;

    typedef enum logic [1:0] {
        PC_RUN         = 2'd0,
        PC_MEM_WAIT    = 2'd1,
        PC_FENCE_DRAIN = 2'd2
    } pipe_ctrl_state_e;

    // Field order is also the bit order of the packed vector, pc_en is the MSB.
    typedef struct packed {
        logic pc_en;
        logic if_id_en;
        logic id_ex_en;
        logic ex_mem_en;
        logic mem_wb_en;
        logic if_id_flush;
        logic id_ex_flush;
    } pipe_stage_ctrl_t;

    // Everything advances, nothing is squashed.
    localparam pipe_stage_ctrl_t CTRL_RUN    = 7'b11111_00;
    // Whole pipe frozen: reset or an outstanding data-memory access.
    localparam pipe_stage_ctrl_t CTRL_HOLD   = 7'b00000_00;
    // Redirect: fetch the new target, squash the two wrong-path slots.
    localparam pipe_stage_ctrl_t CTRL_FLUSH  = 7'b11111_11;
    // Hold PC and IF/ID, push a bubble into EX, let the back end drain.
    localparam pipe_stage_ctrl_t CTRL_BUBBLE = 7'b00111_01;

endpackage

// File: rtl/pipeline_stall_controller_sat_counter.sv
// Free-running up counter that sticks at all-ones instead of wrapping.
module sat_counter #(
    parameter int W = 32
) (
    input  logic         clk,
    input  logic         en,
    input  logic         clr,
    output logic [W-1:0] count
);

    logic [W-1:0] count_q;
    logic [W-1:0] count_d;

    // Next count: clear wins, otherwise step by one unless already saturated.
    always_comb begin
        count_d = count_q;
        if (clr) begin
            count_d = '0;
        end else if (en && (count_q != {W{1'b1}})) begin
            count_d = count_q + W'(1);
        end
    end

    // Count register; clr doubles as the synchronous reset.
    always_ff @(posedge clk) begin
        count_q <= count_d;
    end

    assign count = count_q;

endmodule

// File: rtl/pipeline_stall_controller.sv
// Central sequencer for the PC and the four pipeline registers. Merges memory wait,
// branch redirect, FENCE drain and load-use bubbles into per-stage enables/flushes.
module pipeline_stall_controller
    import pipeline_stall_controller_pkg::*;
#(
    parameter int DRAIN_CYCLES = 3,
    parameter int MEM_TIMEOUT  = 15,
    parameter int CNT_W        = 32
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             insert_nop,
    input  logic             branch_taken,
    input  logic             fence_id,
    input  logic             dmem_req,
    input  logic             dmem_ready,
    output logic             pc_en,
    output logic             if_id_en,
    output logic             id_ex_en,
    output logic             ex_mem_en,
    output logic             mem_wb_en,
    output logic             if_id_flush,
    output logic             id_ex_flush,
    output logic             mem_timeout,
    output logic [CNT_W-1:0] stall_count
);

    localparam int DRAIN_W = (DRAIN_CYCLES < 2) ? 1 : $clog2(DRAIN_CYCLES + 1);
    localparam int WAIT_W  = (MEM_TIMEOUT < 2) ? 1 : $clog2(MEM_TIMEOUT + 1);
    localparam logic [DRAIN_W-1:0] DRAIN_INIT = DRAIN_W'(DRAIN_CYCLES - 1);
    localparam logic [WAIT_W-1:0]  WAIT_MAX   = WAIT_W'(MEM_TIMEOUT);

    pipe_ctrl_state_e   state_q, state_d;
    pipe_ctrl_state_e   ret_state_q, ret_state_d;
    logic [DRAIN_W-1:0] drain_cnt_q, drain_cnt_d;
    logic [WAIT_W-1:0]  wait_cnt_q, wait_cnt_d;
    logic               mem_timeout_q, mem_timeout_d;
    logic               fence_skip_q, fence_skip_d;
    pipe_stage_ctrl_t   ctrl;
    pipe_stage_ctrl_t   ctrl_out;
    pipe_ctrl_state_e   eff_state;
    logic               mem_stall;

    assign mem_stall = dmem_req & ~dmem_ready;

    // The cycle a memory wait ends behaves like the state the wait interrupted.
    assign eff_state = (state_q == PC_MEM_WAIT) ? ret_state_q : state_q;

    // Priority resolution: mem stall, then branch, then fence, then load-use bubble.
    always_comb begin
        ctrl          = CTRL_RUN;
        state_d       = state_q;
        ret_state_d   = ret_state_q;
        drain_cnt_d   = drain_cnt_q;
        wait_cnt_d    = wait_cnt_q;
        fence_skip_d  = 1'b0;

        if (state_q == PC_MEM_WAIT && !dmem_ready) begin
            ctrl         = CTRL_HOLD;
            fence_skip_d = fence_skip_q;
            if (wait_cnt_q < WAIT_MAX) begin
                wait_cnt_d = wait_cnt_q + WAIT_W'(1);
            end
        end else if (state_q != PC_MEM_WAIT && mem_stall) begin
            ctrl         = CTRL_HOLD;
            state_d      = PC_MEM_WAIT;
            ret_state_d  = state_q;
            wait_cnt_d   = WAIT_W'(1);
            fence_skip_d = fence_skip_q;
        end else begin
            state_d    = eff_state;
            wait_cnt_d = '0;
            if (branch_taken) begin
                ctrl        = CTRL_FLUSH;
                drain_cnt_d = '0;
                state_d     = PC_RUN;
            end else if (eff_state == PC_FENCE_DRAIN) begin
                ctrl = CTRL_BUBBLE;
                if (drain_cnt_q != '0) begin
                    drain_cnt_d = drain_cnt_q - DRAIN_W'(1);
                end
                if (drain_cnt_d == '0) begin
                    state_d      = PC_RUN;
                    fence_skip_d = 1'b1;
                end
            end else if (fence_id && !fence_skip_q) begin
                ctrl = CTRL_BUBBLE;
                if (DRAIN_CYCLES <= 1) begin
                    state_d      = PC_RUN;
                    fence_skip_d = 1'b1;
                end else begin
                    state_d     = PC_FENCE_DRAIN;
                    drain_cnt_d = DRAIN_INIT;
                end
            end else if (insert_nop) begin
                ctrl = CTRL_BUBBLE;
            end
        end

        mem_timeout_d = mem_timeout_q |
                        ((state_d == PC_MEM_WAIT) && (wait_cnt_d == WAIT_MAX));
    end

    // Controller state registers with synchronous reset.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q       <= PC_RUN;
            ret_state_q   <= PC_RUN;
            drain_cnt_q   <= '0;
            wait_cnt_q    <= '0;
            mem_timeout_q <= 1'b0;
            fence_skip_q  <= 1'b0;
        end else begin
            state_q       <= state_d;
            ret_state_q   <= ret_state_d;
            drain_cnt_q   <= drain_cnt_d;
            wait_cnt_q    <= wait_cnt_d;
            mem_timeout_q <= mem_timeout_d;
            fence_skip_q  <= fence_skip_d;
        end
    end

    assign ctrl_out    = rst ? CTRL_HOLD : ctrl;
    assign pc_en       = ctrl_out.pc_en;
    assign if_id_en    = ctrl_out.if_id_en;
    assign id_ex_en    = ctrl_out.id_ex_en;
    assign ex_mem_en   = ctrl_out.ex_mem_en;
    assign mem_wb_en   = ctrl_out.mem_wb_en;
    assign if_id_flush = ctrl_out.if_id_flush;
    assign id_ex_flush = ctrl_out.id_ex_flush;
    assign mem_timeout = mem_timeout_q;

    sat_counter #(
        .W (CNT_W)
    ) u_stall_counter (
        .clk   (clk),
        .en    (~ctrl_out.pc_en & ~rst),
        .clr   (rst),
        .count (stall_count)
    );

endmodule

// File: tb/tb_pipeline_stall_controller.sv
// Directed scoreboard bench for pipeline_stall_controller: each stimulus cycle pushes
// its hand-computed control vector, a separate monitor pops and compares at negedge.
module tb_pipeline_stall_controller;

    localparam logic [6:0] C_RUN   = 7'b11111_00;
    localparam logic [6:0] C_HOLD  = 7'b00000_00;
    localparam logic [6:0] C_FLUSH = 7'b11111_11;
    localparam logic [6:0] C_BUB   = 7'b00111_01;

    typedef struct {
        string       name;
        logic [6:0]  ctrl;
        bit          chk_regs;
        logic        timeout;
        logic [31:0] cnt;
    } exp_t;

    logic        clk;
    logic        rst;
    logic        insert_nop;
    logic        branch_taken;
    logic        fence_id;
    logic        dmem_req;
    logic        dmem_ready;
    logic        pc_en;
    logic        if_id_en;
    logic        id_ex_en;
    logic        ex_mem_en;
    logic        mem_wb_en;
    logic        if_id_flush;
    logic        id_ex_flush;
    logic        mem_timeout;
    logic [31:0] stall_count;

    exp_t        sb[$];
    int          checks = 0;
    int          errors = 0;
    bit          regs_known = 0;
    logic [31:0] exp_cnt = 0;

    pipeline_stall_controller #(
        .DRAIN_CYCLES (3),
        .MEM_TIMEOUT  (15),
        .CNT_W        (32)
    ) dut (
        .clk          (clk),
        .rst          (rst),
        .insert_nop   (insert_nop),
        .branch_taken (branch_taken),
        .fence_id     (fence_id),
        .dmem_req     (dmem_req),
        .dmem_ready   (dmem_ready),
        .pc_en        (pc_en),
        .if_id_en     (if_id_en),
        .id_ex_en     (id_ex_en),
        .ex_mem_en    (ex_mem_en),
        .mem_wb_en    (mem_wb_en),
        .if_id_flush  (if_id_flush),
        .id_ex_flush  (id_ex_flush),
        .mem_timeout  (mem_timeout),
        .stall_count  (stall_count)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Drive one cycle of inputs and queue the control vector that cycle must show.
    task automatic applyStimulus(input string name, input logic r, input logic nop,
                                 input logic br, input logic fence, input logic req,
                                 input logic rdy, input logic [6:0] exp_ctrl,
                                 input logic exp_to);
        exp_t e;
        @(posedge clk);
        #1;
        rst          = r;
        insert_nop   = nop;
        branch_taken = br;
        fence_id     = fence;
        dmem_req     = req;
        dmem_ready   = rdy;
        e.name     = name;
        e.ctrl     = exp_ctrl;
        e.chk_regs = regs_known;
        e.timeout  = exp_to;
        e.cnt      = exp_cnt;
        sb.push_back(e);
        if (r) begin
            exp_cnt    = 0;
            regs_known = 1;
        end else if (!exp_ctrl[6]) begin
            exp_cnt = exp_cnt + 1;
        end
    endtask

    // Compare the sampled DUT outputs against one scoreboard entry.
    task automatic checkOutput(input exp_t e);
        logic [6:0] act;
        act = {pc_en, if_id_en, id_ex_en, ex_mem_en, mem_wb_en, if_id_flush, id_ex_flush};
        checks++;
        if (act !== e.ctrl) begin
            errors++;
            $display("[TB] FAIL %s ctrl: got %b expected %b", e.name, act, e.ctrl);
        end
        if (e.chk_regs) begin
            checks++;
            if (mem_timeout !== e.timeout) begin
                errors++;
                $display("[TB] FAIL %s mem_timeout: got %b expected %b", e.name,
                         mem_timeout, e.timeout);
            end
            checks++;
            if (stall_count !== e.cnt) begin
                errors++;
                $display("[TB] FAIL %s stall_count: got %0d expected %0d", e.name,
                         stall_count, e.cnt);
            end
        end
    endtask

    // Monitor: every negedge with a pending expectation is a compare point.
    initial begin
        exp_t e;
        forever begin
            @(negedge clk);
            if (sb.size() > 0) begin
                e = sb.pop_front();
                checkOutput(e);
            end
        end
    end

    // Directed stimulus, one call per clock cycle.
    initial begin
        rst = 1'b1; insert_nop = 1'b0; branch_taken = 1'b0;
        fence_id = 1'b0; dmem_req = 1'b0; dmem_ready = 1'b0;

        // reset then idle
        applyStimulus("rst0", 1, 0, 0, 0, 0, 0, C_HOLD, 0);
        applyStimulus("rst1", 1, 0, 0, 0, 0, 0, C_HOLD, 0);
        for (int i = 0; i < 5; i++)
            applyStimulus("idle", 0, 0, 0, 0, 0, 0, C_RUN, 0);

        // load-use bubble
        applyStimulus("nop", 0, 1, 0, 0, 0, 0, C_BUB, 0);
        applyStimulus("nop_after", 0, 0, 0, 0, 0, 0, C_RUN, 0);

        // fence held through drain, then released by the skip cycle
        applyStimulus("fence_c1", 0, 0, 0, 1, 0, 0, C_BUB, 0);
        applyStimulus("fence_c2", 0, 0, 0, 1, 0, 0, C_BUB, 0);
        applyStimulus("fence_c3", 0, 0, 0, 1, 0, 0, C_BUB, 0);
        applyStimulus("fence_go", 0, 0, 0, 1, 0, 0, C_RUN, 0);
        applyStimulus("fence_idle", 0, 0, 0, 0, 0, 0, C_RUN, 0);

        // branch during drain aborts it
        applyStimulus("fbr_c1", 0, 0, 0, 1, 0, 0, C_BUB, 0);
        applyStimulus("fbr_br", 0, 0, 1, 1, 0, 0, C_FLUSH, 0);
        applyStimulus("fbr_idle", 0, 0, 0, 0, 0, 0, C_RUN, 0);

        // 4-cycle memory wait
        for (int i = 0; i < 4; i++)
            applyStimulus("mw_hold", 0, 0, 0, 0, 1, 0, C_HOLD, 0);
        applyStimulus("mw_ready", 0, 0, 0, 0, 1, 1, C_RUN, 0);
        applyStimulus("mw_idle", 0, 0, 0, 0, 0, 0, C_RUN, 0);

        // memory wait with load-use request ignored
        for (int i = 0; i < 4; i++)
            applyStimulus("mwnop_hold", 0, 1, 0, 0, 1, 0, C_HOLD, 0);
        applyStimulus("mwnop_ready", 0, 0, 0, 0, 1, 1, C_RUN, 0);

        // long wait trips the sticky timeout
        for (int k = 1; k <= 16; k++)
            applyStimulus("to_hold", 0, 0, 0, 0, 1, 0, C_HOLD, (k >= 16) ? 1'b1 : 1'b0);
        applyStimulus("to_ready", 0, 0, 0, 0, 1, 1, C_RUN, 1);
        applyStimulus("to_idle", 0, 0, 0, 0, 0, 0, C_RUN, 1);
        applyStimulus("to_rst0", 1, 0, 0, 0, 0, 0, C_HOLD, 1);
        applyStimulus("to_rst1", 1, 0, 0, 0, 0, 0, C_HOLD, 0);
        applyStimulus("to_clear", 0, 0, 0, 0, 0, 0, C_RUN, 0);

        // memory stall inside a fence drain
        applyStimulus("fm_c1", 0, 0, 0, 1, 0, 0, C_BUB, 0);
        applyStimulus("fm_stall", 0, 0, 0, 1, 1, 0, C_HOLD, 0);
        applyStimulus("fm_wait1", 0, 0, 0, 1, 1, 0, C_HOLD, 0);
        applyStimulus("fm_wait2", 0, 0, 0, 1, 1, 0, C_HOLD, 0);
        applyStimulus("fm_ready", 0, 0, 0, 1, 1, 1, C_BUB, 0);
        applyStimulus("fm_c3", 0, 0, 0, 1, 0, 0, C_BUB, 0);
        applyStimulus("fm_go", 0, 0, 0, 1, 0, 0, C_RUN, 0);
        applyStimulus("fm_idle", 0, 0, 0, 0, 0, 0, C_RUN, 0);

        // all three events at once: branch wins
        applyStimulus("all3", 0, 1, 1, 1, 0, 0, C_FLUSH, 0);
        applyStimulus("all3_idle", 0, 0, 0, 0, 0, 0, C_RUN, 0);

        // reset in the middle of a drain
        applyStimulus("rd_c1", 0, 0, 0, 1, 0, 0, C_BUB, 0);
        applyStimulus("rd_c2", 0, 0, 0, 1, 0, 0, C_BUB, 0);
        applyStimulus("rd_rst", 1, 0, 0, 0, 0, 0, C_HOLD, 0);
        applyStimulus("rd_idle", 0, 0, 0, 0, 0, 0, C_RUN, 0);
        applyStimulus("rd_fence", 0, 0, 0, 1, 0, 0, C_BUB, 0);
        applyStimulus("rd_fence2", 0, 0, 0, 1, 0, 0, C_BUB, 0);
        applyStimulus("rd_fence3", 0, 0, 0, 1, 0, 0, C_BUB, 0);
        applyStimulus("rd_go", 0, 0, 0, 1, 0, 0, C_RUN, 0);
        applyStimulus("rd_end", 0, 0, 0, 0, 0, 0, C_RUN, 0);

        for (int i = 0; i < 10 && sb.size() > 0; i++)
            @(posedge clk);
        if (sb.size() > 0) begin
            errors++;
            $display("[TB] FAIL drain_scoreboard: %0d entries left, expected 0", sb.size());
        end
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
